// File: rtl/noc_pkg.sv
// Shared NoC types and helpers: demux FSM states and the one-hot destination check.
package noc_pkg;

  localparam int unsigned MaxPorts = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } noc_demux_state_e;

  // Callers zero-extend narrower destination vectors to MaxPorts bits.
  function automatic logic is_onehot(logic [MaxPorts-1:0] v);
    return (v != '0) && ((v & (v - MaxPorts'(1))) == '0);
  endfunction

endpackage

// File: rtl/noc_pipe_reg.sv
// Single-entry valid/ready register slice carrying a flit plus a one-hot port select.
module noc_pipe_reg #(
  parameter int unsigned N     = 5,
  parameter int unsigned Width = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_sel,
  input  logic [Width-1:0] in_flit,
  output logic             out_valid,
  output logic [N-1:0]     out_sel,
  output logic [Width-1:0] out_flit,
  input  logic [N-1:0]     out_ready
);

  logic             valid_q;
  logic [N-1:0]     sel_q;
  logic [Width-1:0] flit_q;
  logic             fire;

  // Only the selected port's ready matters; the others are masked off.
  assign fire     = valid_q & |(out_ready & sel_q);
  assign in_ready = ~valid_q | fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
      flit_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      sel_q   <= in_sel;
      flit_q  <= in_flit;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_sel   = sel_q;
  assign out_flit  = flit_q;

endmodule

// File: rtl/noc_onehot_demux.sv
// Flit distributor: steers each packet to the one-hot port named on its head flit, locking
// the route until the tail; malformed packets are swallowed and counted as errors.
module noc_onehot_demux
  import noc_pkg::*;
#(
  parameter int unsigned N           = 5,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned ErrCntWidth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DataWidth-1:0]   in_data,
  input  logic                   in_head,
  input  logic                   in_tail,
  input  logic [N-1:0]           in_dest,
  output logic [N-1:0]           out_valid,
  input  logic [N-1:0]           out_ready,
  output logic [DataWidth-1:0]   out_data,
  output logic                   out_head,
  output logic                   out_tail,
  output logic                   err_pulse,
  output logic [ErrCntWidth-1:0] err_cnt
);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 head;
    logic                 tail;
  } flit_t;

  localparam int unsigned FlitWidth = $bits(flit_t);

  noc_demux_state_e state;
  logic [N-1:0]     lock_sel;
  logic [N-1:0]     fwd_sel;
  logic             accept;
  logic             dest_ok;
  logic             fwd;
  logic             err;
  flit_t            in_flit;
  flit_t            reg_flit;
  logic             reg_valid;
  logic [N-1:0]     reg_sel;

  assign accept  = in_valid & in_ready;
  assign dest_ok = is_onehot(MaxPorts'(in_dest));
  assign in_flit = '{data: in_data, head: in_head, tail: in_tail};

  always_comb begin
    fwd     = 1'b0;
    err     = 1'b0;
    fwd_sel = lock_sel;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (in_head && dest_ok) begin
            fwd     = 1'b1;
            fwd_sel = in_dest;
          end else begin
            err = 1'b1;
          end
        end
        ROUTE: begin
          fwd = 1'b1;
          err = in_head;
        end
        DROP:    ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_sel  <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= err;
      if (err && (err_cnt != '1)) err_cnt <= err_cnt + ErrCntWidth'(1);
      if (accept) begin
        unique case (state)
          IDLE: begin
            if (in_head && !in_tail) begin
              if (dest_ok) begin
                state    <= ROUTE;
                lock_sel <= in_dest;
              end else begin
                state <= DROP;
              end
            end
          end
          ROUTE, DROP: begin
            if (in_tail) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  noc_pipe_reg #(
    .N     (N),
    .Width (FlitWidth)
  ) u_pipe_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fwd),
    .in_ready  (in_ready),
    .in_sel    (fwd_sel),
    .in_flit   (in_flit),
    .out_valid (reg_valid),
    .out_sel   (reg_sel),
    .out_flit  (reg_flit),
    .out_ready (out_ready)
  );

  assign out_valid = {N{reg_valid}} & reg_sel;
  assign out_data  = reg_flit.data;
  assign out_head  = reg_flit.head;
  assign out_tail  = reg_flit.tail;

endmodule

// File: tb/tb_noc_onehot_demux.sv
// Directed self-checking bench for noc_onehot_demux with N=5, DataWidth=32.
module tb_noc_onehot_demux;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_head;
  logic          in_tail;
  logic [N-1:0]  in_dest;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW-1:0] out_data;
  logic          out_head;
  logic          out_tail;
  logic          err_pulse;
  logic [EW-1:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc_onehot_demux #(
    .N           (N),
    .DataWidth   (DW),
    .ErrCntWidth (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_head   (in_head),
    .in_tail   (in_tail),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_head  (out_head),
    .out_tail  (out_tail),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic h, input logic t,
                       input logic [N-1:0] dest);
    in_valid = v;
    in_data  = d;
    in_head  = h;
    in_tail  = t;
    in_dest  = dest;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    out_ready = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    n_cmp++;
    if (out_valid !== 5'b0 || out_data !== 32'h0 || out_head !== 1'b0 || out_tail !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: valid=%b data=%h head=%b tail=%b, want all zero",
               out_valid, out_data, out_head, out_tail);
    end
    n_cmp++;
    if (err_pulse !== 1'b0 || err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_err: pulse=%b cnt=%0d, want 0/0", err_pulse, err_cnt);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = '0;
    drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 5'b00100);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (out_valid !== 5'b00100 || out_data !== 32'hA5A5_0001 || out_head !== 1'b1 ||
        out_tail !== 1'b1) begin
      n_err++;
      $display("FAIL single_out: valid=%b data=%h h=%b t=%b, want 00100 a5a50001 1 1",
               out_valid, out_data, out_head, out_tail);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_full: in_ready=%b want 0", in_ready);
    end
    // Ready on a non-selected port must not release the slot.
    out_ready = 5'b11011;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_other_ready: in_ready=%b want 0", in_ready);
    end
    out_ready = 5'b00100;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_fire_ready: in_ready=%b want 1", in_ready);
    end
    cyc();
    n_cmp++;
    if (out_valid !== 5'b0 || err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL single_drain: valid=%b cnt=%0d, want 00000/0", out_valid, err_cnt);
    end
  endtask

  task automatic test_burst();
    out_ready = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hB000_0000 + i, (i == 0), (i == 3), 5'b00010);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL burst_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      cyc();
      n_cmp++;
      if (out_valid !== 5'b00010 || out_data !== 32'hB000_0000 + i || out_head !== (i == 0) ||
          out_tail !== (i == 3)) begin
        n_err++;
        $display("FAIL burst_out[%0d]: valid=%b data=%h h=%b t=%b", i, out_valid, out_data,
                 out_head, out_tail);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    cyc();
    n_cmp++;
    if (out_valid !== 5'b0) begin
      n_err++;
      $display("FAIL burst_end: valid=%b want 00000", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 5'b11111;
    drive(1'b1, 32'hC000_0000, 1'b1, 1'b0, 5'b00010);
    cyc();
    n_cmp++;
    if (out_valid !== 5'b00010 || out_data !== 32'hC000_0000) begin
      n_err++;
      $display("FAIL stall_f0: valid=%b data=%h want 00010 c0000000", out_valid, out_data);
    end
    drive(1'b1, 32'hC000_0001, 1'b0, 1'b0, 5'b00000);
    cyc();
    drive(1'b1, 32'hC000_0002, 1'b0, 1'b0, 5'b00000);
    out_ready = 5'b11101;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 5'b00010 || out_data !== 32'hC000_0001 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h in_ready=%b want 00010 c0000001 0", i,
                 out_valid, out_data, in_ready);
      end
      cyc();
    end
    out_ready = 5'b11111;
    #1;
    cyc();
    n_cmp++;
    if (out_valid !== 5'b00010 || out_data !== 32'hC000_0002 || out_tail !== 1'b0) begin
      n_err++;
      $display("FAIL stall_f2: valid=%b data=%h tail=%b", out_valid, out_data, out_tail);
    end
    drive(1'b1, 32'hC000_0003, 1'b0, 1'b1, 5'b00000);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (out_valid !== 5'b00010 || out_data !== 32'hC000_0003 || out_tail !== 1'b1) begin
      n_err++;
      $display("FAIL stall_f3: valid=%b data=%h tail=%b", out_valid, out_data, out_tail);
    end
    cyc();
    n_cmp++;
    if (out_valid !== 5'b0 || err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL stall_end: valid=%b cnt=%0d want 00000/0", out_valid, err_cnt);
    end
  endtask

  task automatic test_bad_dest();
    int pulses = 0;
    logic any_valid = 1'b0;
    out_ready = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 32'hD000_0000 + i, (i == 0), (i == 2), 5'b00110);
      else drive(1'b0, '0, 1'b0, 1'b0, '0);
      cyc();
      if (err_pulse === 1'b1) pulses++;
      if (out_valid !== 5'b0) any_valid = 1'b1;
    end
    n_cmp++;
    if (pulses != 1 || err_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL bad_dest_err: pulses=%0d cnt=%0d want 1/1", pulses, err_cnt);
    end
    n_cmp++;
    if (any_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bad_dest_valid: out_valid seen=%b want 0", any_valid);
    end
  endtask

  task automatic test_idle_body();
    out_ready = 5'b11111;
    drive(1'b1, 32'hE000_0000, 1'b0, 1'b0, 5'b10000);
    cyc();
    n_cmp++;
    if (err_pulse !== 1'b1 || out_valid !== 5'b0) begin
      n_err++;
      $display("FAIL idle_body: pulse=%b valid=%b want 1/00000", err_pulse, out_valid);
    end
    drive(1'b1, 32'hE000_0001, 1'b1, 1'b0, 5'b10000);
    cyc();
    n_cmp++;
    if (err_pulse !== 1'b0 || out_valid !== 5'b10000 || out_data !== 32'hE000_0001) begin
      n_err++;
      $display("FAIL idle_head: pulse=%b valid=%b data=%h", err_pulse, out_valid, out_data);
    end
    drive(1'b1, 32'hE000_0002, 1'b0, 1'b1, 5'b00000);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (out_valid !== 5'b10000 || out_data !== 32'hE000_0002 || out_tail !== 1'b1 ||
        err_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL idle_tail: valid=%b data=%h tail=%b cnt=%0d", out_valid, out_data, out_tail,
               err_cnt);
    end
    cyc();
  endtask

  task automatic test_route_head();
    out_ready = 5'b11111;
    drive(1'b1, 32'hF000_0000, 1'b1, 1'b0, 5'b01000);
    cyc();
    // A second head inside a locked packet is forwarded on the locked port and flagged.
    drive(1'b1, 32'hF000_0001, 1'b1, 1'b1, 5'b00001);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (out_valid !== 5'b01000 || out_data !== 32'hF000_0001 || err_pulse !== 1'b1 ||
        err_cnt !== 16'd3) begin
      n_err++;
      $display("FAIL route_head: valid=%b data=%h pulse=%b cnt=%0d want 01000 f0000001 1 3",
               out_valid, out_data, err_pulse, err_cnt);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic any_valid = 1'b0;
    out_ready = 5'b11111;
    drive(1'b1, 32'h1000_0000, 1'b1, 1'b0, 5'b00001);
    cyc();
    drive(1'b1, 32'h1000_0001, 1'b0, 1'b0, 5'b00000);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 5'b0 || err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear: valid=%b cnt=%0d want 00000/0", out_valid, err_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1'b1, 32'h1000_0002 + i, 1'b0, (i == 1), 5'b00000);
      else drive(1'b0, '0, 1'b0, 1'b0, '0);
      cyc();
      if (err_pulse === 1'b1) pulses++;
      if (out_valid !== 5'b0) any_valid = 1'b1;
    end
    n_cmp++;
    if (pulses != 2 || err_cnt !== 16'd2 || any_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_err: pulses=%0d cnt=%0d valid_seen=%b want 2/2/0", pulses,
               err_cnt, any_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_stall();
    test_bad_dest();
    test_idle_body();
    test_route_head();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
